enigma_frame_buffer: RTL
========================

# enigma_frame_buffer

- Parametrised message-frame buffer between the symbol source and the Enigma encoding core.
- Accepts a frame of plaintext symbols (length fixed by a start command) into an input RAM, rejecting out-of-alphabet symbols.
- Streams the frame into the core under valid/ready flow control, captures the encoded symbols into an output RAM, then plays the frame out to the consumer under valid/ready.
- Supersedes the fixed 7-bit/128-deep wrapper: configurable width, depth and alphabet; backpressure on both sides; length checking; abort.

## Interface
- SYMB_W, 7: symbol width in bits.
- DEPTH, 128: maximum frame length in symbols (power of two, ≥2).
- ALPHA, 26: alphabet size; legal symbols are 1..ALPHA (ALPHA < 2^SYMB_W).
- CNT_W, $clog2(DEPTH+1): derived width for lengths and counters; not to be overridden.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle frame start; samples symb_numb_i.
- symb_numb_i  in  CNT_W  frame length.
- abort_i  in  1  synchronous abort, returns block to IDLE.
- symb_val_i  in  1  wrap_i valid.
- wrap_i  in  SYMB_W  plaintext symbol.
- wrg_symb_o  out  1  combinational: symb_val_i in LOAD with illegal wrap_i.
- len_err_o  out  1  one-cycle pulse: start rejected.
- err_cnt_o  out  8  illegal symbols in current frame, saturating at 255.
- in_en_o  out  SYMB_W  symbol to core.
- en_val_o  out  1  in_en_o valid.
- en_rdy_i  in  1  core accepts in_en_o.
- out_en_i  in  SYMB_W  encoded symbol from core.
- encod_val_i  in  1  out_en_i valid; core never stalls on this side.
- wrap_o  out  SYMB_W  encoded output symbol.
- wrap_val_o  out  1  wrap_o valid.
- wrap_rdy_i  in  1  consumer accepts wrap_o.
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  one-cycle pulse after last output handshake.

## Operation
- FSM states: IDLE, LOAD, ENCODE, DRAIN.
- IDLE:
  - start_i with 1 ≤ symb_numb_i ≤ DEPTH: latch length L, clear counters and err_cnt_o, go to LOAD.
  - start_i with symb_numb_i = 0 or > DEPTH: pulse len_err_o next cycle, stay in IDLE.
- LOAD:
  - Legal symbol (symb_val_i, 1 ≤ wrap_i ≤ ALPHA): written to in_mem[wr_cnt], wr_cnt increments.
  - Illegal symbol: discarded, wrg_symb_o high the same cycle, err_cnt_o increments.
  - On the cycle the L-th legal symbol is written, next state is ENCODE.
- ENCODE:
  - Issues in_mem[0..L-1] in order, one per en_val_o && en_rdy_i handshake.
  - en_val_o/in_en_o hold steady while en_rdy_i is low.
  - Each encod_val_i writes out_en_i to out_mem[ret_cnt] and increments ret_cnt.
  - encod_val_i with ret_cnt = L is ignored.
  - When ret_cnt reaches L, go to DRAIN.
- DRAIN:
  - Presents out_mem[0..L-1] in order, advancing one per wrap_val_o && wrap_rdy_i handshake.
  - After handshake L: done_o pulses, state returns to IDLE.
- Signals ignored outside their state:
  - start_i outside IDLE.
  - symb_val_i outside LOAD (wrg_symb_o stays 0).
  - encod_val_i in IDLE and LOAD.
- abort_i: in any state, forces IDLE on the next edge. en_val_o and wrap_val_o drop the same edge; counters clear; no done_o. abort_i has priority over start_i.
- Counters are CNT_W bits and never wrap; RAM addresses use the low $clog2(DEPTH) bits.

## Timing
- Reset values: state IDLE, all counters 0. in_en_o, en_val_o, wrap_o, wrap_val_o, len_err_o, done_o, err_cnt_o, busy_o all 0. RAMs are not reset.
- Registered outputs: in_en_o, en_val_o, wrap_o, wrap_val_o, done_o, len_err_o.
- busy_o is registered (decoded from state): high the cycle after an accepted start_i, low the cycle done_o is high.
- Input path:
  - en_val_o first rises 1 cycle after entering ENCODE.
  - With en_rdy_i held high, one symbol per cycle with no bubbles; L symbols occupy L consecutive cycles.
  - en_val_o falls the cycle after the L-th handshake.
- Output path:
  - wrap_val_o first rises 1 cycle after entering DRAIN.
  - With wrap_rdy_i held high, one symbol per cycle with no bubbles.
- done_o is coincident with the cycle after the last wrap handshake, and is the same edge the state returns to IDLE.
- A new start_i is accepted on the cycle done_o is high.
- Asynchronous reset mid-frame: frame lost, all outputs go immediately to their reset values.

## Test plan
- L=5, symbols 1,2,3,4,5 back-to-back; core echoes +1 with 2-cycle latency; both ready held high:
  - en_val_o for 5 consecutive cycles.
  - wrap_o = 2,3,4,5,6 on 5 consecutive cycles, then done_o.
- L=3, input 0,4,27,9,26 (ALPHA=26):
  - wrg_symb_o high on 0 and 27; err_cnt_o = 2.
  - Frame contents 4,9,26.
- symb_numb_i=0, then symb_numb_i=DEPTH+1:
  - Two len_err_o pulses, busy_o stays 0.
  - A following start_i with L=DEPTH fills the RAM and completes with DEPTH outputs.
- en_rdy_i toggling 1,0,0,1,… and wrap_rdy_i low for 4 cycles mid-drain:
  - in_en_o and wrap_o held stable while not ready.
  - No symbol duplicated or dropped.
- abort_i during ENCODE after 2 of 6 handshakes: IDLE next cycle, en_val_o = 0, no done_o. Next frame L=2 completes correctly.
- Async reset pulse during DRAIN: all outputs 0 immediately; new frame after reset completes correctly.

Source files
------------

// File: rtl/enigma_frame_buffer.sv
// enigma_frame_buffer: message-frame RAM between symbol source and Enigma core.
// Loads a frame, streams it through the core, then drains the encoded frame.
module enigma_frame_buffer #(
  parameter int SYMB_W = 7,
  parameter int DEPTH  = 128,
  parameter int ALPHA  = 26,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  symb_numb_i,
  input  logic              abort_i,
  input  logic              symb_val_i,
  input  logic [SYMB_W-1:0] wrap_i,
  output logic              wrg_symb_o,
  output logic              len_err_o,
  output logic [7:0]        err_cnt_o,
  output logic [SYMB_W-1:0] in_en_o,
  output logic              en_val_o,
  input  logic              en_rdy_i,
  input  logic [SYMB_W-1:0] out_en_i,
  input  logic              encod_val_i,
  output logic [SYMB_W-1:0] wrap_o,
  output logic              wrap_val_o,
  input  logic              wrap_rdy_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ENC   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE     = CNT_W'(1);
  localparam logic [SYMB_W-1:0] ALPHA_C = SYMB_W'(ALPHA);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  iss_cnt_q, iss_cnt_d;
  logic [CNT_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [SYMB_W-1:0] in_en_q, in_en_d;
  logic              en_val_q, en_val_d;
  logic [SYMB_W-1:0] wrap_q, wrap_d;
  logic              wrap_val_q, wrap_val_d;
  logic              done_q, done_d;
  logic              len_err_q, len_err_d;

  logic [SYMB_W-1:0] in_mem  [DEPTH];
  logic [SYMB_W-1:0] out_mem [DEPTH];

  logic              legal;
  logic              in_load;
  logic              in_we;
  logic              out_we;
  logic              len_ok;
  logic [SYMB_W-1:0] in_rdata;
  logic [SYMB_W-1:0] out_rdata;

  assign legal   = (wrap_i != '0) && (wrap_i <= ALPHA_C);
  assign in_load = (state_q == S_LOAD) && symb_val_i;
  assign in_we   = in_load && legal && (wr_cnt_q < len_q);
  assign out_we  = (state_q == S_ENC) && encod_val_i
                   && (ret_cnt_q < len_q);
  assign len_ok  = (symb_numb_i != '0)
                   && (symb_numb_i <= DEPTH_C);

  assign in_rdata  = in_mem[iss_cnt_q[AW-1:0]];
  assign out_rdata = out_mem[rd_cnt_q[AW-1:0]];

  assign wrg_symb_o = in_load && !legal;
  assign len_err_o  = len_err_q;
  assign err_cnt_o  = err_cnt_q;
  assign in_en_o    = in_en_q;
  assign en_val_o   = en_val_q;
  assign wrap_o     = wrap_q;
  assign wrap_val_o = wrap_val_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;

  // Frame RAMs: plaintext in, encoded out; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (in_we) begin
      in_mem[wr_cnt_q[AW-1:0]] <= wrap_i;
    end
    if (out_we) begin
      out_mem[ret_cnt_q[AW-1:0]] <= out_en_i;
    end
  end

  // Next-state: FSM, counters and both registered stream ports.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_cnt_d   = wr_cnt_q;
    iss_cnt_d  = iss_cnt_q;
    ret_cnt_d  = ret_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    err_cnt_d  = err_cnt_q;
    in_en_d    = in_en_q;
    en_val_d   = en_val_q;
    wrap_d     = wrap_q;
    wrap_val_d = wrap_val_q;
    done_d     = 1'b0;
    len_err_d  = 1'b0;

    if (abort_i) begin
      state_d    = S_IDLE;
      wr_cnt_d   = '0;
      iss_cnt_d  = '0;
      ret_cnt_d  = '0;
      rd_cnt_d   = '0;
      err_cnt_d  = '0;
      en_val_d   = 1'b0;
      wrap_val_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_ok) begin
              state_d   = S_LOAD;
              len_d     = symb_numb_i;
              wr_cnt_d  = '0;
              iss_cnt_d = '0;
              ret_cnt_d = '0;
              rd_cnt_d  = '0;
              err_cnt_d = '0;
            end else begin
              len_err_d = 1'b1;
            end
          end
        end

        S_LOAD: begin
          if (wrg_symb_o && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          if (in_we) begin
            wr_cnt_d = wr_cnt_q + ONE;
            if ((wr_cnt_q + ONE) == len_q) begin
              state_d = S_ENC;
            end
          end
        end

        S_ENC: begin
          // Refill the output register when empty or accepted.
          if (!en_val_q || en_rdy_i) begin
            if (iss_cnt_q < len_q) begin
              en_val_d  = 1'b1;
              in_en_d   = in_rdata;
              iss_cnt_d = iss_cnt_q + ONE;
            end else begin
              en_val_d = 1'b0;
            end
          end
          if (out_we) begin
            ret_cnt_d = ret_cnt_q + ONE;
            if ((ret_cnt_q + ONE) == len_q) begin
              state_d  = S_DRAIN;
              en_val_d = 1'b0;
            end
          end
        end

        S_DRAIN: begin
          if (!wrap_val_q || wrap_rdy_i) begin
            if (rd_cnt_q < len_q) begin
              wrap_val_d = 1'b1;
              wrap_d     = out_rdata;
              rd_cnt_d   = rd_cnt_q + ONE;
            end else if (wrap_val_q) begin
              wrap_val_d = 1'b0;
              done_d     = 1'b1;
              state_d    = S_IDLE;
            end
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      wr_cnt_q   <= '0;
      iss_cnt_q  <= '0;
      ret_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      err_cnt_q  <= '0;
      in_en_q    <= '0;
      en_val_q   <= 1'b0;
      wrap_q     <= '0;
      wrap_val_q <= 1'b0;
      done_q     <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_cnt_q   <= wr_cnt_d;
      iss_cnt_q  <= iss_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      err_cnt_q  <= err_cnt_d;
      in_en_q    <= in_en_d;
      en_val_q   <= en_val_d;
      wrap_q     <= wrap_d;
      wrap_val_q <= wrap_val_d;
      done_q     <= done_d;
      len_err_q  <= len_err_d;
    end
  end

endmodule
